// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_mac
//  Description : Serial multiply-accumulate for one MLP neuron. Accumulates
//                N_INPUTS signed (x, w) products onto a signed bias and
//                presents the pre-activation sum, optionally ReLU'd.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac #(
    parameter int N_INPUTS = 62,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 21,
    parameter int RELU     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out
);

    localparam int c_CNT_W  = $clog2(N_INPUTS + 1);
    localparam int c_PROD_W = 2 * DATA_W;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [ACC_W-1:0]         r_acc;
    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_in_ready;
    logic                     r_busy;
    logic                     r_out_valid;
    logic [ACC_W-1:0]         r_acc_out;

    logic signed [c_PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]           w_prod_ext;
    logic [ACC_W-1:0]           w_bias_ext;
    logic [ACC_W-1:0]           w_sum;
    logic [ACC_W-1:0]           w_result;
    logic                       w_beat;

    assign w_prod     = $signed(x) * $signed(w);
    assign w_prod_ext = {{(ACC_W - c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias};
    assign w_sum      = r_acc + w_prod_ext;
    // in_ready is registered high exactly while in S_ACC, so it doubles as the state qualifier
    assign w_beat     = in_valid & r_in_ready;
    assign w_result   = ((RELU != 0) && w_sum[ACC_W-1]) ? '0 : w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc      <= w_bias_ext;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_beat) begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_LAST) begin
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_acc_out   <= w_result;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_acc_out   <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_acc_out   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc_out;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_mac
//  Description : Directed self-checking bench for neuron_mac (N=4 with and
//                without ReLU sharing stimulus, plus an N=63 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

    logic        clk;
    logic        rst;
    logic        start_ab;
    logic        start_c;
    logic [7:0]  bias;
    logic        in_valid;
    logic [7:0]  x;
    logic [7:0]  w;
    logic        out_ready;

    logic        in_ready_a, busy_a, out_valid_a;
    logic [20:0] acc_out_a;
    logic        in_ready_b, busy_b, out_valid_b;
    logic [20:0] acc_out_b;
    logic        in_ready_c, busy_c, out_valid_c;
    logic [20:0] acc_out_c;

    int n_checks;
    int n_errors;

    logic [7:0] xs [4];
    logic [7:0] ws [4];

    neuron_mac #(.N_INPUTS(4), .DATA_W(8), .ACC_W(21), .RELU(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_ab), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_a), .x(x), .w(w),
        .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .acc_out(acc_out_a)
    );

    neuron_mac #(.N_INPUTS(4), .DATA_W(8), .ACC_W(21), .RELU(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_ab), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_b), .x(x), .w(w),
        .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .acc_out(acc_out_b)
    );

    neuron_mac #(.N_INPUTS(63), .DATA_W(8), .ACC_W(21), .RELU(1)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_c), .x(x), .w(w),
        .busy(busy_c), .out_valid(out_valid_c), .out_ready(out_ready),
        .acc_out(acc_out_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One N=4 activation on the shared pairs; rnd gaps in_valid, hold stalls out_ready,
    // keep_start leaves start high and swaps bias to -14 after the start is accepted.
    task automatic run_ab(input string tag, input logic [7:0] b, input bit rnd, input int hold,
                          input bit keep_start, input logic [20:0] exp_a, input logic [20:0] exp_b);
        int  i;
        int  cyc;
        bit  beat;
        bias      = b;
        start_ab  = 1'b1;
        out_ready = (hold == 0);
        tick();
        if (keep_start) bias = 8'hF2;
        else            start_ab = 1'b0;
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
        check({tag, "_inrdy"}, {31'd0, in_ready_a}, 32'd1);
        i   = 0;
        cyc = 0;
        while (i < 4 && cyc < 200) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            x        = in_valid ? xs[i] : 8'($urandom);
            w        = in_valid ? ws[i] : 8'($urandom);
            beat     = in_valid && in_ready_a;
            tick();
            cyc++;
            if (beat) begin
                i++;
                check({tag, "_latency"}, {31'd0, out_valid_a}, {31'd0, 1'(i == 4)});
            end
        end
        in_valid = 1'b0;
        if (i < 4) check({tag, "_timeout"}, 32'(i), 32'd4);
        check({tag, "_acc_a"}, {11'd0, acc_out_a}, {11'd0, exp_a});
        check({tag, "_acc_b"}, {11'd0, acc_out_b}, {11'd0, exp_b});
        check({tag, "_inrdy_done"}, {31'd0, in_ready_a}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_valid"}, {31'd0, out_valid_a}, 32'd1);
            check({tag, "_hold_acc"}, {11'd0, acc_out_a}, {11'd0, exp_a});
            check({tag, "_hold_inrdy"}, {31'd0, in_ready_a}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, {31'd0, out_valid_a}, 32'd0);
        check({tag, "_acc_zero"}, {11'd0, acc_out_a}, 32'd0);
        check({tag, "_busy_idle"}, {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        xs        = '{8'sd1, 8'sd3, -8'sd2, 8'sd0};
        ws        = '{8'sd2, 8'sd4, 8'sd5, 8'sd7};
        rst       = 1'b1;
        start_ab  = 1'b0;
        start_c   = 1'b0;
        bias      = 8'd0;
        in_valid  = 1'b0;
        x         = 8'd0;
        w         = 8'd0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_inrdy", {31'd0, in_ready_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_acc", {11'd0, acc_out_a}, 32'd0);
        check("rst_c_busy", {31'd0, busy_c}, 32'd0);
        check("rst_c_acc", {11'd0, acc_out_c}, 32'd0);

        // products 2+12-10+0 = 4
        run_ab("basic", 8'd3, 1'b0, 0, 1'b0, 21'd7, 21'd7);
        tick();
        run_ab("neg30", 8'hE2, 1'b0, 0, 1'b0, 21'd0, 21'h1FFFE6);
        tick();
        run_ab("neg14", 8'hF2, 1'b0, 0, 1'b0, 21'd0, 21'h1FFFF6);
        tick();
        run_ab("stall", 8'd3, 1'b1, 5, 1'b0, 21'd7, 21'd7);
        tick();

        // abort after two beats with a third pending
        bias     = 8'd100;
        start_ab = 1'b1;
        tick();
        start_ab = 1'b0;
        in_valid = 1'b1;
        x        = xs[0];
        w        = ws[0];
        tick();
        x        = xs[1];
        w        = ws[1];
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_inrdy", {31'd0, in_ready_a}, 32'd0);
        check("abort_valid", {31'd0, out_valid_a}, 32'd0);
        run_ab("post_abort", 8'd3, 1'b0, 0, 1'b0, 21'd7, 21'd7);
        tick();

        // start held through ACC/DONE; the re-armed start takes bias -14 after one idle cycle
        run_ab("start_held", 8'd3, 1'b0, 2, 1'b1, 21'd7, 21'd7);
        run_ab("restart", 8'hF2, 1'b0, 0, 1'b0, 21'd0, 21'h1FFFF6);
        tick();

        // 63 * 16384 + 127
        bias      = 8'd127;
        start_c   = 1'b1;
        out_ready = 1'b0;
        tick();
        start_c  = 1'b0;
        in_valid = 1'b1;
        x        = 8'h80;
        w        = 8'h80;
        for (int k = 0; k < 63; k++) begin
            if (k == 62) check("big_prelast", {31'd0, out_valid_c}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("big_valid", {31'd0, out_valid_c}, 32'd1);
        check("big_acc", {11'd0, acc_out_c}, 32'd1032319);
        out_ready = 1'b1;
        tick();
        check("big_drop", {31'd0, out_valid_c}, 32'd0);
        check("big_busy", {31'd0, busy_c}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
